ahb_rr_arbiter_op: RTL and testbench
====================================

// Module: ahb_rr_arbiter_op
// PURPOSE
// - Arbiter for a bus-matrix output stage. Shares one slave port among NUM_PORTS input stages.
// - Takes registered requests (held_tran & sel) and monitors the muxed slave-side
//   HTRANS/HBURST/HMASTLOCK/HREADY. Drives the registered address-phase port select
//   (addr_in_port) and no_port to the output-stage mux.
// - Grants round-robin. A grant is held through fixed-length bursts, INCR bursts and
//   locked sequences.
// PARAMETERS
// - NUM_PORTS  2  number of requesting input stages (2..4)
// - PORT_W     1  width of addr_in_port; must equal clog2(NUM_PORTS), minimum 1
// PORTS
// - HCLK          in   1          clock; all state updates on rising edge
// - HRESET        in   1          synchronous, active-high reset
// - req_port      in   NUM_PORTS  per-port request, bit i = port i
// - HREADYM       in   1          muxed HREADY of the slave port; arbitration only when 1
// - HSELM         in   1          muxed HSEL from the currently granted port
// - HTRANSM       in   2          muxed HTRANS: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
// - HBURSTM       in   3          muxed HBURST
// - HMASTLOCKM    in   1          HMASTLOCK already masked by HSEL/hsel_lock
// - addr_in_port  out  PORT_W     granted port index (registered)
// - no_port       out  1          1 = no port granted; mux outputs idle defaults (registered)
// BEHAVIOUR
// - Reset: addr_in_port=0, no_port=1, beat_cnt=0, state=IDLE, rr_last=NUM_PORTS-1.
// - Every update is qualified by HREADYM=1. With HREADYM=0 all state and outputs hold.
// - FSM states:
//   - IDLE: no_port=1.
//   - SINGLE: grant owned; next HREADYM cycle is an arbitration point.
//   - BURST: fixed-length burst in progress.
//   - UNDEF: INCR burst in progress.
//   - LOCK: locked sequence in progress.
// - Arbitration point = HREADYM & state in {IDLE, SINGLE}, or exit from BURST/UNDEF/LOCK (below).
//   - Winner = first requesting port after rr_last, searching upward with wrap.
//   - On win: addr_in_port <= winner, no_port <= 0, rr_last <= winner.
//   - No requests at an arbitration point: no_port <= 1; addr_in_port holds its last value.
// - Latency: a request seen at an arbitration point is reflected on addr_in_port/no_port
//   one HCLK later.
// - Transition on owner NONSEQ with HSELM=1 (checked in order):
//   - HMASTLOCKM=1 -> LOCK.
//   - HBURST=INCR4/WRAP4 -> BURST, beat_cnt=3.
//   - HBURST=INCR8/WRAP8 -> BURST, beat_cnt=7.
//   - HBURST=INCR16/WRAP16 -> BURST, beat_cnt=15.
//   - HBURST=INCR -> UNDEF.
//   - Otherwise -> SINGLE.
// - BURST:
//   - SEQ decrements beat_cnt. BUSY holds.
//   - beat_cnt reaching 0 on a SEQ -> arbitration point on the next HREADYM cycle.
//   - Early termination (IDLE, NONSEQ or HSELM=0 before beat_cnt=0): beat_cnt <= 0 and
//     re-arbitrate immediately. A NONSEQ from the same owner is a fresh request and
//     competes normally.
// - UNDEF: held while HTRANSM in {BUSY, SEQ}. IDLE/NONSEQ -> arbitration point.
// - LOCK:
//   - Grant held while HMASTLOCKM=1, even if req_port of the owner is 0.
//   - HMASTLOCKM=0 -> arbitration point.
//   - Lock has priority over burst counting.
// - Simultaneous requests: resolved purely by round-robin order; no starvation
//   (max wait = NUM_PORTS-1 tenures).
// - Owner request dropping mid-burst/lock does not release the grant early, except
//   through early termination.
// - HRESET asserted mid-burst or mid-lock: all state returns to reset values on that edge.
// CONFIGURATION
// - AHB_ARB_FIXED_PRIO_EN defined: round-robin replaced by fixed priority, lowest index
//   wins. rr_last is unused (may be removed). Burst/lock holding is unchanged.
// - Undefined (default): round-robin as above.
// TESTING
// - Reset: assert HRESET 2 cycles, req_port=2'b11 -> addr_in_port=0, no_port=1 during
//   reset; first grant after release = port 0 (rr_last=1).
// - Round-robin: req_port=2'b11, singles (NONSEQ, HBURST=000), HREADYM=1 -> grant
//   alternates 0,1,0,1 on successive transfers.
// - Burst hold: port1 INCR4 (NONSEQ+3 SEQ) with req_port=2'b11, HREADYM low 2 cycles on
//   beat 2 -> grant stays 1 for all 4 beats, then switches to 0.
// - Early termination: port0 INCR8, IDLE after 3rd SEQ, req_port[1]=1 -> grant moves to
//   port 1 on the next HREADYM edge, beat_cnt=0.
// - Lock: port0 HMASTLOCKM=1 across 3 transfers with req_port[0]=0 midway and
//   req_port[1]=1 -> grant stays 0 until HMASTLOCKM=0, then 1.
// - Fixed prio (AHB_ARB_FIXED_PRIO_EN): req_port=2'b11 for 4 singles -> grant=0 every time.

Source files
------------

// File: rtl/ahb_rr_arbiter_op_if.sv
// Bus-side signals between the output-stage arbiter and the logic that feeds it.
// The slave modport is the arbiter's view; master is the side driving requests and muxed AHB controls.
interface ahb_rr_arbiter_op_if #(
    parameter int NUM_PORTS = 2,
    parameter int PORT_W    = 1
);
    logic [NUM_PORTS-1:0] req_port;
    logic                 HREADYM;
    logic                 HSELM;
    logic [1:0]           HTRANSM;
    logic [2:0]           HBURSTM;
    logic                 HMASTLOCKM;
    logic [PORT_W-1:0]    addr_in_port;
    logic                 no_port;

    modport master (
        output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, no_port
    );

    modport slave (
        input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, no_port
    );
endinterface

// File: rtl/ahb_rr_arbiter_op.sv
// Bus-matrix output-stage arbiter: round-robin grant held through bursts, INCR and locked sequences.
// Define AHB_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest index wins).
module ahb_rr_arbiter_op #(
    parameter int NUM_PORTS = 2,
    parameter int PORT_W    = 1
) (
    input  logic                HCLK,
    input  logic                HRESET,
    ahb_rr_arbiter_op_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SINGLE = 3'd1,
        ST_BURST  = 3'd2,
        ST_UNDEF  = 3'd3,
        ST_LOCK   = 3'd4
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_INCR   = 3'b001;

    state_t               state_reg, state_next;
    logic [3:0]           beat_cnt_reg, beat_cnt_next;
    logic [PORT_W-1:0]    addr_in_port_reg, addr_in_port_next;
    logic                 no_port_reg, no_port_next;
    logic                 arb_en;
    logic                 any_req;
    logic                 owner_nonseq;
    logic [3:0]           burst_len;
    logic [NUM_PORTS-1:0] search_req;
    logic [PORT_W-1:0]    winner;

    assign any_req      = |bus.req_port;
    assign owner_nonseq = !no_port_reg && bus.HSELM && (bus.HTRANSM == TR_NONSEQ);

    // Remaining SEQ beats after the NONSEQ of a fixed-length burst; 0 = not fixed-length.
    always_comb begin
        case (bus.HBURSTM)
            3'b010, 3'b011: burst_len = 4'd3;
            3'b100, 3'b101: burst_len = 4'd7;
            3'b110, 3'b111: burst_len = 4'd15;
            default:        burst_len = 4'd0;
        endcase
    end

`ifdef AHB_ARB_FIXED_PRIO_EN
    assign search_req = bus.req_port;
`else
    logic [PORT_W-1:0]    rr_last_reg, rr_last_next;
    logic [NUM_PORTS-1:0] hi_mask;
    logic [NUM_PORTS-1:0] hi_req;

    // Ports strictly above the last winner are searched first; otherwise wrap to the full set.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_hi_mask
            assign hi_mask[gi] = (gi > int'(rr_last_reg));
        end
    endgenerate

    assign hi_req     = bus.req_port & hi_mask;
    assign search_req = (|hi_req) ? hi_req : bus.req_port;
`endif

    // Lowest set bit of the search vector.
    always_comb begin
        winner = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (search_req[i]) winner = PORT_W'(i);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg        <= ST_IDLE;
            beat_cnt_reg     <= 4'd0;
            addr_in_port_reg <= '0;
            no_port_reg      <= 1'b1;
`ifndef AHB_ARB_FIXED_PRIO_EN
            rr_last_reg      <= PORT_W'(NUM_PORTS - 1);
`endif
        end else begin
            state_reg        <= state_next;
            beat_cnt_reg     <= beat_cnt_next;
            addr_in_port_reg <= addr_in_port_next;
            no_port_reg      <= no_port_next;
`ifndef AHB_ARB_FIXED_PRIO_EN
            rr_last_reg      <= rr_last_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        arb_en        = 1'b0;
        if (bus.HREADYM) begin
            case (state_reg)
                ST_IDLE, ST_SINGLE: begin
                    // Lock outranks burst classification of the owner's NONSEQ.
                    if (owner_nonseq && bus.HMASTLOCKM) begin
                        state_next = ST_LOCK;
                    end else if (owner_nonseq && (burst_len != 4'd0)) begin
                        state_next    = ST_BURST;
                        beat_cnt_next = burst_len;
                    end else if (owner_nonseq && (bus.HBURSTM == BU_INCR)) begin
                        state_next = ST_UNDEF;
                    end else begin
                        arb_en = 1'b1;
                    end
                end
                ST_BURST: begin
                    if (bus.HSELM && (bus.HTRANSM == TR_SEQ)) begin
                        beat_cnt_next = beat_cnt_reg - 4'd1;
                        if (beat_cnt_reg <= 4'd1) begin
                            beat_cnt_next = 4'd0;
                            state_next    = ST_SINGLE;
                        end
                    end else if (!(bus.HSELM && (bus.HTRANSM == TR_BUSY))) begin
                        beat_cnt_next = 4'd0;
                        arb_en        = 1'b1;
                    end
                end
                ST_UNDEF: begin
                    if ((bus.HTRANSM == TR_IDLE) || (bus.HTRANSM == TR_NONSEQ)) arb_en = 1'b1;
                end
                ST_LOCK: begin
                    if (!bus.HMASTLOCKM) arb_en = 1'b1;
                end
                default: arb_en = 1'b1;
            endcase
            if (arb_en) state_next = any_req ? ST_SINGLE : ST_IDLE;
        end
    end

    always_comb begin
        addr_in_port_next = addr_in_port_reg;
        no_port_next      = no_port_reg;
`ifndef AHB_ARB_FIXED_PRIO_EN
        rr_last_next      = rr_last_reg;
`endif
        if (arb_en) begin
            if (any_req) begin
                addr_in_port_next = winner;
                no_port_next      = 1'b0;
`ifndef AHB_ARB_FIXED_PRIO_EN
                rr_last_next      = winner;
`endif
            end else begin
                no_port_next = 1'b1;
            end
        end
    end

    assign bus.addr_in_port = addr_in_port_reg;
    assign bus.no_port      = no_port_reg;
endmodule

// File: tb/tb_ahb_rr_arbiter_op.sv
// Directed bench for ahb_rr_arbiter_op: reset, round-robin, burst hold, early termination, lock.
module tb_ahb_rr_arbiter_op;
    logic HCLK;
    logic HRESET;
    int   total;
    int   bad;

    ahb_rr_arbiter_op_if #(.NUM_PORTS(2), .PORT_W(1)) bus ();

    ahb_rr_arbiter_op #(.NUM_PORTS(2), .PORT_W(1)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus.slave)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic rdy, input logic sel,
                         input logic [1:0] trans, input logic [2:0] burst, input logic lock);
        bus.req_port   = req;
        bus.HREADYM    = rdy;
        bus.HSELM      = sel;
        bus.HTRANSM    = trans;
        bus.HBURSTM    = burst;
        bus.HMASTLOCKM = lock;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        HRESET = 1'b1;
        drive(2'b11, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);

        // Reset held two cycles with both ports requesting
        step();
        step();
        chk("rst_addr", 32'(bus.addr_in_port), 32'd0);
        chk("rst_no_port", 32'(bus.no_port), 32'd1);

        // First grant after release goes to port 0
        HRESET = 1'b0;
        step();
        chk("first_grant", 32'(bus.addr_in_port), 32'd0);
        chk("first_no_port", 32'(bus.no_port), 32'd0);

        // Round-robin over single transfers
        drive(2'b11, 1'b1, 1'b1, 2'b10, 3'b000, 1'b0);
        step(); chk("rr_1", 32'(bus.addr_in_port), 32'd1);
        step(); chk("rr_2", 32'(bus.addr_in_port), 32'd0);
        step(); chk("rr_3", 32'(bus.addr_in_port), 32'd1);

        // Port 1 INCR4 with two wait states on beat 2
        drive(2'b11, 1'b1, 1'b1, 2'b10, 3'b011, 1'b0);
        step(); chk("b4_nonseq", 32'(bus.addr_in_port), 32'd1);
        chk("b4_cnt3", 32'(dut.beat_cnt_reg), 32'd3);
        drive(2'b11, 1'b1, 1'b1, 2'b11, 3'b011, 1'b0);
        step(); chk("b4_seq1", 32'(bus.addr_in_port), 32'd1);
        bus.HREADYM = 1'b0;
        step();
        step(); chk("b4_wait", 32'(bus.addr_in_port), 32'd1);
        chk("b4_wait_cnt", 32'(dut.beat_cnt_reg), 32'd2);
        bus.HREADYM = 1'b1;
        step(); chk("b4_seq2", 32'(bus.addr_in_port), 32'd1);
        step(); chk("b4_seq3", 32'(bus.addr_in_port), 32'd1);
        drive(2'b11, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0);
        step(); chk("b4_after", 32'(bus.addr_in_port), 32'd0);

        // Port 0 INCR8 terminated early with IDLE after third SEQ
        drive(2'b11, 1'b1, 1'b1, 2'b10, 3'b101, 1'b0);
        step(); chk("b8_nonseq", 32'(bus.addr_in_port), 32'd0);
        drive(2'b11, 1'b1, 1'b1, 2'b11, 3'b101, 1'b0);
        step(); step(); step();
        chk("b8_seq3", 32'(bus.addr_in_port), 32'd0);
        chk("b8_cnt4", 32'(dut.beat_cnt_reg), 32'd4);
        drive(2'b11, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0);
        step(); chk("b8_early_grant", 32'(bus.addr_in_port), 32'd1);
        chk("b8_early_cnt", 32'(dut.beat_cnt_reg), 32'd0);

        // Locked sequence from port 0; its request drops while locked
        drive(2'b01, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0);
        step(); chk("lk_grant0", 32'(bus.addr_in_port), 32'd0);
        drive(2'b11, 1'b1, 1'b1, 2'b10, 3'b000, 1'b1);
        step(); chk("lk_xfer1", 32'(bus.addr_in_port), 32'd0);
        drive(2'b10, 1'b1, 1'b1, 2'b10, 3'b000, 1'b1);
        step(); chk("lk_xfer2", 32'(bus.addr_in_port), 32'd0);
        step(); chk("lk_xfer3", 32'(bus.addr_in_port), 32'd0);
        chk("lk_no_port", 32'(bus.no_port), 32'd0);
        drive(2'b10, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0);
        step(); chk("lk_release", 32'(bus.addr_in_port), 32'd1);

        // No requests: no_port rises, index holds
        drive(2'b00, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
        step(); chk("none_no_port", 32'(bus.no_port), 32'd1);
        chk("none_addr", 32'(bus.addr_in_port), 32'd1);

        // Reset asserted in the middle of an INCR16
        drive(2'b01, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
        step(); chk("r16_grant", 32'(bus.addr_in_port), 32'd0);
        drive(2'b11, 1'b1, 1'b1, 2'b10, 3'b111, 1'b0);
        step(); chk("r16_cnt", 32'(dut.beat_cnt_reg), 32'd15);
        HRESET = 1'b1;
        step();
        chk("r16_no_port", 32'(bus.no_port), 32'd1);
        chk("r16_cnt0", 32'(dut.beat_cnt_reg), 32'd0);
        HRESET = 1'b0;
        drive(2'b11, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
        step(); chk("r16_regrant", 32'(bus.addr_in_port), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
